// File: rtl/sim_pkg.sv
// Shared types and constants for the circuit-solver step sequencer.
package sim_pkg;

  // Solver phase sequence: idle, branch-current update, node-voltage update,
  // then hand-off of the finished step to the capture path.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BRANCH = 2'd1,
    S_NODE   = 2'd2,
    S_SAMPLE = 2'd3
  } state_t;

  // Source samples are signed Q16.16.
  localparam int FRAC_W     = 16;
  localparam int CNT_W_DEF  = 10;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/sim_src_gen.sv
// Square-wave source generator: holds the phase counter, the latched
// period/high/amplitude settings and the registered source value.
// load_i restarts the waveform from the live inputs; adv_i moves one step on
// and re-latches the settings at each period boundary.
module sim_src_gen
  import sim_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [CNT_W-1:0]  high_i,
  input  logic [DATA_W-1:0] amp_i,
  output logic [DATA_W-1:0] src_o
);

  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [DATA_W-1:0] amp_q, amp_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic [CNT_W-1:0]  per_eff;

  // A period of zero behaves as one step.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] per);
    return (per == '0) ? CNT_W'(1) : per;
  endfunction

  // Low phase first: amplitude once the count reaches period-high.
  function automatic logic [DATA_W-1:0] wave(input logic [CNT_W-1:0]  cnt,
                                             input logic [CNT_W-1:0]  per,
                                             input logic [CNT_W-1:0]  hi,
                                             input logic [DATA_W-1:0] amp);
    logic [CNT_W-1:0] p;
    p = eff_period(per);
    if (hi >= p) return amp;
    if (cnt >= (p - hi)) return amp;
    return '0;
  endfunction

  assign per_eff = eff_period(per_q);

  // Next phase count, settings and source value on load or advance.
  always_comb begin
    pcnt_d = pcnt_q;
    per_d  = per_q;
    high_d = high_q;
    amp_d  = amp_q;
    src_d  = src_q;
    if (load_i || (adv_i && (pcnt_q >= (per_eff - CNT_W'(1))))) begin
      pcnt_d = '0;
      per_d  = period_i;
      high_d = high_i;
      amp_d  = amp_i;
      src_d  = wave('0, period_i, high_i, amp_i);
    end else if (adv_i) begin
      pcnt_d = pcnt_q + CNT_W'(1);
      src_d  = wave(pcnt_q + CNT_W'(1), per_q, high_q, amp_q);
    end
  end

  // Waveform state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
      per_q  <= '0;
      high_q <= '0;
      amp_q  <= '0;
      src_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      per_q  <= per_d;
      high_q <= high_d;
      amp_q  <= amp_d;
      src_q  <= src_d;
    end
  end

  assign src_o = src_q;

endmodule

// File: rtl/sim_step_sequencer.sv
// Two-phase solver step sequencer: branch strobe, node strobe, then a
// valid/ready hand-off per step, with start/stop/single-step control.
// Optional build macro SIM_STEP_LIMIT_EN adds step_limit_i/done_o so a run
// ends by itself after a programmed number of steps.
module sim_step_sequencer
  import sim_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              step_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [CNT_W-1:0]  high_i,
  input  logic [DATA_W-1:0] amp_i,
  output logic [DATA_W-1:0] src_o,
  output logic              ph_branch_o,
  output logic              ph_node_o,
  output logic              smp_valid_o,
  input  logic              smp_ready_i,
  output logic [31:0]       step_cnt_o,
  output logic              busy_o
`ifdef SIM_STEP_LIMIT_EN
  ,
  input  logic [31:0]       step_limit_i,
  output logic              done_o
`endif
);

  state_t      state_q;
  logic        branch_q, node_q, valid_q, busy_q;
  logic        stop_pend_q, one_shot_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_inc;
  logic        go, hs, limit_hit, end_run;

  // Stop beats start; a step request is always a single step.
  assign go      = (start_i || step_i) && !stop_i;
  assign hs      = (state_q == S_SAMPLE) && smp_ready_i;
  assign cnt_inc = cnt_q + 32'd1;

`ifdef SIM_STEP_LIMIT_EN
  logic done_q;
  assign limit_hit = (step_limit_i != 32'd0) && (cnt_inc == step_limit_i);
  assign done_o    = done_q;
`else
  assign limit_hit = 1'b0;
`endif

  // A stop arriving in the handshake cycle itself still ends the run here.
  assign end_run = one_shot_q || stop_pend_q || stop_i || limit_hit;

  // Sequencer FSM with registered strobes, flags and step counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      branch_q    <= 1'b0;
      node_q      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      one_shot_q  <= 1'b0;
      cnt_q       <= '0;
`ifdef SIM_STEP_LIMIT_EN
      done_q      <= 1'b0;
`endif
    end else begin
      branch_q <= 1'b0;
      node_q   <= 1'b0;
`ifdef SIM_STEP_LIMIT_EN
      done_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q    <= S_BRANCH;
            branch_q   <= 1'b1;
            busy_q     <= 1'b1;
            one_shot_q <= step_i;
`ifdef SIM_STEP_LIMIT_EN
            if (!step_i) cnt_q <= '0;
`endif
          end
        end
        S_BRANCH: begin
          state_q <= S_NODE;
          node_q  <= 1'b1;
          if (stop_i) stop_pend_q <= 1'b1;
        end
        S_NODE: begin
          state_q <= S_SAMPLE;
          valid_q <= 1'b1;
          if (stop_i) stop_pend_q <= 1'b1;
        end
        S_SAMPLE: begin
          if (smp_ready_i) begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_inc;
            if (end_run) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
              one_shot_q  <= 1'b0;
`ifdef SIM_STEP_LIMIT_EN
              done_q      <= limit_hit;
`endif
            end else begin
              state_q  <= S_BRANCH;
              branch_q <= 1'b1;
            end
          end else if (stop_i) begin
            stop_pend_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  sim_src_gen #(
    .CNT_W  (CNT_W),
    .DATA_W (DATA_W)
  ) u_src_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   ((state_q == S_IDLE) && go),
    .adv_i    (hs),
    .period_i (period_i),
    .high_i   (high_i),
    .amp_i    (amp_i),
    .src_o    (src_o)
  );

  assign ph_branch_o = branch_q;
  assign ph_node_o   = node_q;
  assign smp_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign step_cnt_o  = cnt_q;

endmodule
